// File: rtl/sync_arb_pkg.sv
// Shared types for the sync-stage arbiter: FSM states, owner tag layout, default word width.
package sync_arb_pkg;

  localparam int DW_DEFAULT = 32;
  localparam int TAG_ID_W   = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/sync_stage_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request at or above ptr, wrapping to 0.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   gid,
  output logic            hit
);

  logic found;

  always_comb begin
    grant = '0;
    gid   = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!found && req[i] && (((int'(ptr) + k) % NREQ) == i)) begin
          found    = 1'b1;
          grant[i] = 1'b1;
          gid      = IW'(i);
        end
      end
    end
    hit = found;
  end

endmodule

// File: rtl/sync_stage_arbiter.sv
// Round-robin sharing of one two-cycle sync delay stage among NREQ requesters.
// Optional per-requester grant / stall statistics enabled by SYNC_ARB_STATS_EN.
module sync_stage_arbiter
  import sync_arb_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int DW        = DW_DEFAULT,
  parameter int STAGE_LAT = 2,
  parameter int GAP       = 2
) (
  input  logic             clk,
  input  logic             GlobalReset,
  input  logic [NREQ-1:0]  req_valid,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]  req_ack,
  output logic             stage_srdy,
  output logic [DW-1:0]    stage_data,
  input  logic [DW-1:0]    stage_sync,
  output logic [NREQ-1:0]  resp_valid,
  output logic [DW-1:0]    resp_data,
  output logic             busy
`ifdef SYNC_ARB_STATS_EN
  ,
  output logic [NREQ*16-1:0] stat_grants,
  output logic [15:0]        stat_stall
`endif
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(GAP + 1);

  arb_state_t state, state_nx;
  logic [IW-1:0]       rr_ptr;
  logic [CW-1:0]       gap_cnt;
  logic [NREQ-1:0]     pick_grant;
  logic [IW-1:0]       pick_gid;
  logic                pick_hit;
  logic                grant_fire;
  logic [DW-1:0]       pick_data;
  logic [TAG_ID_W-1:0] push_id;
  logic [IW-1:0]       next_ptr;
  logic                tags_live;
  tag_t                tag_pipe [STAGE_LAT+1];

  rr_pick #(.NREQ(NREQ)) u_rr_pick (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .gid   (pick_gid),
    .hit   (pick_hit)
  );

  always_comb begin
    pick_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_grant[i]) pick_data = req_data[i*DW +: DW];
    end
  end

  always_comb begin
    push_id = '0;
    push_id[IW-1:0] = pick_gid;
  end

  assign next_ptr = (pick_gid == IW'(NREQ - 1)) ? '0 : pick_gid + IW'(1);

  always_ff @(posedge clk or negedge GlobalReset) begin
    if (!GlobalReset) state <= IDLE;
    else              state <= state_nx;
  end

  // A grant may only start from IDLE or once GAP cycles of the previous issue have elapsed.
  always_comb begin
    state_nx   = state;
    grant_fire = 1'b0;
    unique case (state)
      IDLE: begin
        if (pick_hit) begin
          grant_fire = 1'b1;
          state_nx   = ISSUE;
        end
      end
      ISSUE: state_nx = HOLD;
      HOLD: begin
        if (gap_cnt >= CW'(GAP)) begin
          if (pick_hit) begin
            grant_fire = 1'b1;
            state_nx   = ISSUE;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Issue stage p0: grant pulse, stage handoff; stage_data only moves on a grant edge.
  always_ff @(posedge clk or negedge GlobalReset) begin
    if (!GlobalReset) begin
      rr_ptr     <= '0;
      gap_cnt    <= '0;
      req_ack    <= '0;
      stage_srdy <= 1'b0;
      stage_data <= '0;
    end else begin
      req_ack    <= '0;
      stage_srdy <= 1'b0;
      if (grant_fire) begin
        req_ack    <= pick_grant;
        stage_srdy <= 1'b1;
        stage_data <= pick_data;
        rr_ptr     <= next_ptr;
        gap_cnt    <= CW'(1);
      end else if (state != IDLE && gap_cnt < CW'(GAP)) begin
        gap_cnt <= gap_cnt + CW'(1);
      end
    end
  end

  // Owner-tag pipe: tail lines up with the stage result, so resp lands STAGE_LAT+1 after srdy.
  always_ff @(posedge clk or negedge GlobalReset) begin
    if (!GlobalReset) begin
      for (int i = 0; i <= STAGE_LAT; i++) tag_pipe[i] <= '0;
    end else begin
      tag_pipe[0] <= grant_fire ? tag_t'{valid: 1'b1, id: push_id} : '0;
      for (int i = 1; i <= STAGE_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
    end
  end

  // Response stage: one-hot owner pulse with the captured stage word.
  always_ff @(posedge clk or negedge GlobalReset) begin
    if (!GlobalReset) begin
      resp_valid <= '0;
      resp_data  <= '0;
    end else begin
      resp_valid <= '0;
      if (tag_pipe[STAGE_LAT].valid) begin
        resp_data <= stage_sync;
        for (int i = 0; i < NREQ; i++) begin
          if (tag_pipe[STAGE_LAT].id == TAG_ID_W'(i)) resp_valid[i] <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    tags_live = 1'b0;
    for (int i = 0; i <= STAGE_LAT; i++) tags_live = tags_live | tag_pipe[i].valid;
  end

  assign busy = (state != IDLE) || tags_live;

`ifdef SYNC_ARB_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or negedge GlobalReset) begin
    if (!GlobalReset) begin
      stat_grants <= '0;
      stat_stall  <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (grant_fire && pick_grant[i]) stat_grants[i*16 +: 16] <= sat_inc(stat_grants[i*16 +: 16]);
      end
      if (pick_hit && !grant_fire) stat_stall <= sat_inc(stat_stall);
    end
  end
`endif

endmodule

// File: tb/tb_sync_stage_arbiter.sv
// Directed bench for sync_stage_arbiter with a behavioural two-cycle stage (XOR-tagged data).
module tb_sync_stage_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 32;
  localparam logic [DW-1:0] STAGE_KEY = 32'h5A5A5A5A;

  logic               clk = 1'b0;
  logic               GlobalReset;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ack;
  logic               stage_srdy;
  logic [DW-1:0]      stage_data;
  logic [DW-1:0]      stage_sync;
  logic [NREQ-1:0]    resp_valid;
  logic [DW-1:0]      resp_data;
  logic               busy;
`ifdef SYNC_ARB_STATS_EN
  logic [NREQ*16-1:0] stat_grants;
  logic [15:0]        stat_stall;
`endif

  int checks = 0;
  int errors = 0;

  logic [3:0]  t2_ack  [12];
  logic [3:0]  t2_resp [12];
  logic [31:0] t2_data [12];

  always #5 clk = ~clk;

  sync_stage_arbiter #(.NREQ(NREQ), .DW(DW), .STAGE_LAT(2), .GAP(2)) dut (
    .clk         (clk),
    .GlobalReset (GlobalReset),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ack     (req_ack),
    .stage_srdy  (stage_srdy),
    .stage_data  (stage_data),
    .stage_sync  (stage_sync),
    .resp_valid  (resp_valid),
    .resp_data   (resp_data),
    .busy        (busy)
`ifdef SYNC_ARB_STATS_EN
    ,
    .stat_grants (stat_grants),
    .stat_stall  (stat_stall)
`endif
  );

  logic [DW-1:0] s1, s2;
  always @(posedge clk) begin
    s1 <= stage_srdy ? (stage_data ^ STAGE_KEY) : '0;
    s2 <= s1;
  end
  assign stage_sync = s2;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    GlobalReset = 1'b0;
    req_valid   = '0;
    req_data    = '0;
    repeat (3) step();
    check("rst_ack",  32'(req_ack), 32'h0);
    check("rst_srdy", 32'(stage_srdy), 32'h0);
    check("rst_data", stage_data, 32'h0);
    check("rst_resp", 32'(resp_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    GlobalReset = 1'b1;
    step();

    // Single request from requester 0
    req_data[0*DW +: DW] = 32'hDEADBEEF;
    req_valid = 4'b0001;
    step();
    check("t1_ack",  32'(req_ack), 32'h1);
    check("t1_srdy", 32'(stage_srdy), 32'h1);
    check("t1_data", stage_data, 32'hDEADBEEF);
    check("t1_busy", 32'(busy), 32'h1);
    req_valid = 4'b0000;
    step();
    check("t1_ack_off",  32'(req_ack), 32'h0);
    check("t1_srdy_off", 32'(stage_srdy), 32'h0);
    check("t1_data_hold", stage_data, 32'hDEADBEEF);
    step();
    check("t1_resp_early", 32'(resp_valid), 32'h0);
    step();
    check("t1_resp", 32'(resp_valid), 32'h1);
    check("t1_resp_data", resp_data, 32'h84F7E4B5);
    step();
    check("t1_resp_off", 32'(resp_valid), 32'h0);
    check("t1_idle", 32'(busy), 32'h0);

    // Requester 1 alone moves the pointer to 2, then 0 and 1 request: wrap gives 0 then 1
    req_data[0*DW +: DW] = 32'hA5A5A5A5;
    req_data[1*DW +: DW] = 32'h0F0F0F0F;
    req_valid = 4'b0010;
    step();
    check("t3_pre_ack", 32'(req_ack), 32'h2);
    req_valid = 4'b0000;
    step();
    step();
    req_valid = 4'b0011;
    step();
    check("t3_ack0", 32'(req_ack), 32'h1);
    check("t3_data0", stage_data, 32'hA5A5A5A5);
    check("t3_resp_pre", 32'(resp_valid), 32'h2);
    check("t3_resp_pre_data", resp_data, 32'h55555555);
    req_valid = 4'b0010;
    step();
    check("t3_ack_gap", 32'(req_ack), 32'h0);
    step();
    check("t3_ack1", 32'(req_ack), 32'h2);
    check("t3_data1", stage_data, 32'h0F0F0F0F);
    req_valid = 4'b0000;
    step();
    check("t3_resp0", 32'(resp_valid), 32'h1);
    check("t3_resp0_data", resp_data, 32'hFFFFFFFF);
    step();
    step();
    check("t3_resp1", 32'(resp_valid), 32'h2);
    check("t3_resp1_data", resp_data, 32'h55555555);
    step();
    check("t3_idle", 32'(busy), 32'h0);

    // Reset while in HOLD drops the in-flight result
    req_data[2*DW +: DW] = 32'h13579BDF;
    req_valid = 4'b0100;
    step();
    check("t4_ack", 32'(req_ack), 32'h4);
    check("t4_data", stage_data, 32'h13579BDF);
    req_valid = 4'b0000;
    step();
    GlobalReset = 1'b0;
    #1;
    check("t4_rst_data", stage_data, 32'h0);
    check("t4_rst_srdy", 32'(stage_srdy), 32'h0);
    check("t4_rst_ack",  32'(req_ack), 32'h0);
    check("t4_rst_busy", 32'(busy), 32'h0);
    step();
    GlobalReset = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      check($sformatf("t4_no_resp[%0d]", c), 32'(resp_valid), 32'h0);
    end

    // All four requesting continuously after reset: 0,1,2,3,0 spaced two cycles
    req_data[0*DW +: DW] = 32'h11111111;
    req_data[1*DW +: DW] = 32'h22222222;
    req_data[2*DW +: DW] = 32'h33333333;
    req_data[3*DW +: DW] = 32'h44444444;
    t2_ack  = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000,
                4'b1000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
    t2_resp = '{4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0010,
                4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0001};
    t2_data = '{32'h0, 32'h0, 32'h0, 32'h4B4B4B4B, 32'h0, 32'h78787878,
                32'h0, 32'h69696969, 32'h0, 32'h1E1E1E1E, 32'h0, 32'h4B4B4B4B};
    req_valid = 4'b1111;
    for (int c = 0; c < 12; c++) begin
      step();
      check($sformatf("t2_ack[%0d]", c), 32'(req_ack), 32'(t2_ack[c]));
      check($sformatf("t2_resp[%0d]", c), 32'(resp_valid), 32'(t2_resp[c]));
      if (t2_resp[c] != 4'b0000)
        check($sformatf("t2_data[%0d]", c), resp_data, t2_data[c]);
      if (c == 8) req_valid = 4'b0000;
    end

    // Requester 1 withdraws while requester 3 is served
    req_data[3*DW +: DW] = 32'h12345678;
    req_valid = 4'b1000;
    step();
    check("t5_ack3", 32'(req_ack), 32'h8);
    req_valid = 4'b0010;
    step();
    check("t5_ack_a", 32'(req_ack), 32'h0);
    req_valid = 4'b0000;
    step();
    check("t5_ack_b", 32'(req_ack), 32'h0);
    step();
    check("t5_resp3", 32'(resp_valid), 32'h8);
    check("t5_resp3_data", resp_data, 32'h486E0C22);
    for (int c = 0; c < 3; c++) begin
      step();
      check($sformatf("t5_ack_none[%0d]", c), 32'(req_ack), 32'h0);
      check($sformatf("t5_resp_none[%0d]", c), 32'(resp_valid), 32'h0);
    end

`ifdef SYNC_ARB_STATS_EN
    GlobalReset = 1'b0;
    step();
    GlobalReset = 1'b1;
    check("st_rst_stall", 32'(stat_stall), 32'h0);
    for (int g = 0; g < 10; g++) begin
      req_valid = 4'b0100;
      step();
      req_valid = 4'b0000;
      step();
      step();
    end
    check("st_grants2", 32'(stat_grants[2*16 +: 16]), 32'd10);
    check("st_stall0", 32'(stat_stall), 32'd0);
    req_valid = 4'b0111;
    repeat (6) step();
    req_valid = 4'b0000;
    repeat (4) step();
    check("st_stall3", 32'(stat_stall), 32'd3);
    check("st_grants0", 32'(stat_grants[0*16 +: 16]), 32'd1);
    check("st_grants1", 32'(stat_grants[1*16 +: 16]), 32'd1);
    check("st_grants2b", 32'(stat_grants[2*16 +: 16]), 32'd11);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
